// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the processor run controller, its core and its bench.
// State encodings are fixed so that waveforms and external monitors can decode them.
package proc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RST_HOLD = 3'd2,
        ST_RUN      = 3'd3,
        ST_HALTED   = 3'd4,
        ST_TIMEOUT  = 3'd5,
        ST_ERROR    = 3'd6
    } state_t;

    localparam int DEF_RST_CYCLES     = 2;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    // lc-2k opcode field sits in bits [24:22] of the instruction word
    localparam logic [2:0] LC2K_OP_HALT = 3'b110;

endpackage

// File: rtl/sat_counter.sv
// Purpose: up-counter with synchronous clear that sticks at all-ones.
// Latency: value updates one cycle after clr/inc; clr has priority over inc.
// Backpressure: none, inc is sampled every cycle.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/proc_run_ctrl.sv
// Purpose: hold core in reset, stream program into imem, release, count and watch the run.
// Latency: imem write one cycle after ld handshake; status outputs registered from next state.
// Backpressure: ld_ready high only in LOAD; words are taken one per cycle with no internal buffering.
module proc_run_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              skip_load,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    input  logic              core_halt,
    input  logic              core_retire,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  retire_count
);

    localparam int                HW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HW-1:0]     HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [HW-1:0]     hold_cnt;
    logic              ld_fire;
    logic              cnt_clr;
    logic              cyc_inc;
    logic              ret_inc;

    assign ld_fire = ld_valid && (state == ST_LOAD);
    assign cnt_clr = (state_nxt == ST_RST_HOLD) && (state != ST_RST_HOLD);
    assign cyc_inc = (state == ST_RUN);
    assign ret_inc = (state == ST_RUN) && core_retire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_HALTED, ST_TIMEOUT, ST_ERROR: begin
                if (start) begin
                    state_nxt = skip_load ? ST_RST_HOLD : ST_LOAD;
                end
            end
            ST_LOAD: begin
                // a last word in the top slot still fits; only a further word overflows
                if (ld_fire) begin
                    if (ld_last) begin
                        state_nxt = ST_RST_HOLD;
                    end else if (addr == ADDR_MAX) begin
                        state_nxt = ST_ERROR;
                    end
                end
            end
            ST_RST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (core_halt) begin
                    state_nxt = ST_HALTED;
                end else if ((TIMEOUT_CYCLES != 0) && (cycle_count == TO_LAST)) begin
                    state_nxt = ST_TIMEOUT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr         <= '0;
            words_loaded <= '0;
            hold_cnt     <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
        end else begin
            imem_we <= ld_fire;
            if (ld_fire) begin
                imem_addr    <= addr;
                imem_wdata   <= ld_data;
                addr         <= addr + 1'b1;
                words_loaded <= words_loaded + 1'b1;
            end
            if ((state_nxt == ST_LOAD) && (state != ST_LOAD)) begin
                addr         <= '0;
                words_loaded <= '0;
            end
            hold_cnt <= (state == ST_RST_HOLD) ? hold_cnt + 1'b1 : '0;
        end
    end

    // status is registered from the next state so it lines up with the state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_rst  <= 1'b1;
            ld_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timed_out <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            core_rst  <= (state_nxt != ST_RUN);
            ld_ready  <= (state_nxt == ST_LOAD);
            busy      <= (state_nxt == ST_RST_HOLD) || (state_nxt == ST_LOAD) || (state_nxt == ST_RUN);
            done      <= (state_nxt == ST_HALTED);
            timed_out <= (state_nxt == ST_TIMEOUT);
            load_err  <= (state_nxt == ST_ERROR);
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (cyc_inc),
        .value (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (ret_inc),
        .value (retire_count)
    );

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Bench for proc_run_ctrl: directed sequences, scoreboarded imem writes and end-of-run status.
module tb_proc_run_ctrl;
    import proc_ctrl_pkg::*;

    localparam logic [31:0] HALT_WORD = {7'b0, LC2K_OP_HALT, 22'b0};
    localparam logic [31:0] LW_WORD   = {7'b0, 3'b010, 3'd1, 3'd0, 16'd2};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, skip_load = 1'b0;
    logic        ld_valid = 1'b0, ld_last = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_ready, imem_we, core_rst;
    logic [1:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_halt = 1'b0, core_retire = 1'b0;
    logic        busy, done, timed_out, load_err;
    logic [2:0]  words_loaded;
    logic [31:0] cycle_count, retire_count;

    always #5 clk = ~clk;

    proc_run_ctrl #(
        .RST_CYCLES(2), .ADDR_W(2), .DATA_W(32), .CNT_W(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .skip_load(skip_load),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .core_halt(core_halt), .core_retire(core_retire),
        .busy(busy), .done(done), .timed_out(timed_out), .load_err(load_err),
        .words_loaded(words_loaded), .cycle_count(cycle_count), .retire_count(retire_count)
    );

    typedef struct packed {
        logic [1:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct packed {
        logic        dn;
        logic        to;
        logic        err;
        logic        crst;
        logic [2:0]  wl;
        logic [31:0] cyc;
        logic [31:0] ret;
    } stat_t;

    wr_t   wq[$];
    stat_t sq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic [1:0] exp_addr = '0;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void flag(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event expected none", name);
    endfunction

    function automatic stat_t mk_stat(input logic dn, input logic to, input logic err,
                                      input logic [2:0] wl, input logic [31:0] cyc,
                                      input logic [31:0] ret);
        stat_t s;
        s.dn = dn; s.to = to; s.err = err; s.crst = 1'b1;
        s.wl = wl; s.cyc = cyc; s.ret = ret;
        return s;
    endfunction

    // monitor: imem writes and the rising edge of any terminal status
    logic  prev_fin = 1'b0;
    logic  fin;
    wr_t   e_w;
    stat_t e_s, a_s;
    always @(negedge clk) begin
        if (rst && imem_we) begin
            if (wq.size() == 0) begin
                flag("unexpected_imem_write");
            end else begin
                e_w = wq.pop_front();
                chk("imem_write", {96'b0, imem_addr, imem_wdata}, {96'b0, e_w});
            end
        end
        fin = done | timed_out | load_err;
        if (fin && !prev_fin) begin
            a_s = {done, timed_out, load_err, core_rst, words_loaded, cycle_count, retire_count};
            if (sq.size() == 0) begin
                flag("unexpected_status_event");
            end else begin
                e_s = sq.pop_front();
                chk("status_event", {57'b0, a_s}, {57'b0, e_s});
            end
        end
        prev_fin = fin;
    end

    task automatic do_start(input logic skip);
        start = 1'b1;
        skip_load = skip;
        if (!skip) exp_addr = '0;
        @(negedge clk);
        start = 1'b0;
        skip_load = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        logic acc = 1'b0;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (ld_ready) begin
                wq.push_back({exp_addr, d});
                exp_addr = exp_addr + 2'd1;
                acc = 1'b1;
            end
            @(negedge clk);
        end
        if (!acc) flag("ld_ready_timeout");
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_data  = 32'hDEAD_BEEF;
    endtask

    task automatic wait_run(input int exp_hold);
        int n = 0;
        while (core_rst && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("rst_hold_len", 128'(n), 128'(exp_hold));
    endtask

    task automatic run_core(input int n, input int halt_at, input logic [31:0] no_ret);
        for (int i = 1; i <= n; i++) begin
            core_retire = !no_ret[i-1];
            core_halt   = (i == halt_at);
            @(negedge clk);
        end
        core_retire = 1'b0;
        core_halt   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_flags", {core_rst, ld_ready, imem_we, busy, done, timed_out, load_err}, 7'b1000000);
        chk("reset_counts", {words_loaded, cycle_count, retire_count}, '0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {core_rst, busy, ld_ready}, 3'b100);

        // load two words and halt in the second RUN cycle
        sq.push_back(mk_stat(1'b1, 1'b0, 1'b0, 3'd2, 32'd2, 32'd2));
        do_start(1'b0);
        chk("load_entry", {ld_ready, busy, core_rst, words_loaded}, {3'b111, 3'd0});
        send_word(LW_WORD, 1'b0);
        send_word(HALT_WORD, 1'b1);
        wait_run(2);
        run_core(2, 2, 32'h0);
        chk("halted_flags", {done, busy, core_rst, timed_out}, 4'b1010);

        // watchdog with no halt, re-run without loading
        sq.push_back(mk_stat(1'b0, 1'b1, 1'b0, 3'd2, 32'd16, 32'd16));
        do_start(1'b1);
        chk("skip_clears_counts", {busy, core_rst, ld_ready, cycle_count, retire_count, words_loaded},
            {3'b110, 64'd0, 3'd2});
        wait_run(2);
        run_core(16, 0, 32'h0);
        chk("timeout_flags", {timed_out, busy, core_rst, done}, 4'b1010);

        // restart after timeout; halt coincides with the watchdog limit
        sq.push_back(mk_stat(1'b1, 1'b0, 1'b0, 3'd2, 32'd16, 32'd16));
        do_start(1'b1);
        chk("restart_after_timeout", {busy, timed_out, cycle_count, retire_count}, {2'b10, 64'd0});
        wait_run(2);
        run_core(16, 16, 32'h0);
        chk("halt_beats_timeout", {done, timed_out}, 2'b10);

        // overflow: four words into a four-entry memory without ld_last
        sq.push_back(mk_stat(1'b0, 1'b0, 1'b1, 3'd4, 32'd16, 32'd16));
        do_start(1'b0);
        for (int i = 0; i < 4; i++) send_word(32'hA000_0000 + 32'(i), 1'b0);
        repeat (3) @(negedge clk);
        chk("overflow_hold", {load_err, core_rst, busy, ld_ready, imem_we}, 5'b11000);

        // back-pressured load then a run with three retire gaps
        sq.push_back(mk_stat(1'b1, 1'b0, 1'b0, 3'd3, 32'd8, 32'd5));
        do_start(1'b0);
        send_word(32'h1111_0001, 1'b0);
        @(negedge clk);
        send_word(32'h2222_0002, 1'b0);
        @(negedge clk);
        send_word(32'h3333_0003, 1'b1);
        wait_run(2);
        run_core(8, 8, 32'h0000_001A);

        // asynchronous reset in the middle of a run
        do_start(1'b1);
        wait_run(2);
        run_core(5, 0, 32'h0);
        chk("mid_run_counting", {busy, core_rst, cycle_count}, {2'b10, 32'd5});
        #2 rst = 1'b0;
        #1;
        chk("async_reset_flags", {core_rst, busy, done, ld_ready, imem_we}, 5'b10000);
        chk("async_reset_counts", {words_loaded, cycle_count, retire_count}, '0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_async_reset", {core_rst, busy, done, timed_out, load_err}, 5'b10000);

        chk("pending_writes", 128'(wq.size()), 128'(0));
        chk("pending_status", 128'(sq.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/proc_run_ctrl.md
Name: proc_run_ctrl

Overview:
- Synthesizable run controller placed between the host/bench and the processor core (single- or multi-cycle).
- Holds the core in reset, streams a program into instruction memory, and releases reset.
- Counts cycles and retired instructions, detects halt, and enforces a watchdog timeout.
- Replaces hand-timed reset/finish delays with a parametrised, observable handshake.

Parameters:
- RST_CYCLES, 2, core reset hold length in clk cycles (>=1).
- ADDR_W, 16, instruction memory address width.
- DATA_W, 32, instruction word width.
- CNT_W, 32, width of the cycle and retire counters.
- TIMEOUT_CYCLES, 4096, RUN cycles before watchdog fires (0 = disabled).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset for this block.
- start  input  1  pulse: begin a sequence from IDLE/HALTED/TIMEOUT/ERROR.
- skip_load  input  1  sampled with start; 1 = keep existing imem contents.
- ld_valid  input  1  host load word valid.
- ld_data  input  DATA_W  host load word.
- ld_last  input  1  marks final load word.
- ld_ready  output  1  controller accepts load word.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  DATA_W  write data.
- core_rst  output  1  active-high reset to the core.
- core_halt  input  1  core has executed halt.
- core_retire  input  1  core retired an instruction this cycle (tie to 1 for single-cycle).
- busy  output  1  state is RST_HOLD, LOAD or RUN.
- done  output  1  state is HALTED.
- timed_out  output  1  state is TIMEOUT.
- load_err  output  1  state is ERROR (load overflow).
- words_loaded  output  ADDR_W+1  words written in the last load.
- cycle_count  output  CNT_W  RUN cycles elapsed.
- retire_count  output  CNT_W  instructions retired in RUN.

Behaviour:
- **Reset (rst=0, async):**
  - state=IDLE; core_rst=1; ld_ready=0; imem_we=0; imem_addr=0; imem_wdata=0.
  - words_loaded, cycle_count and retire_count = 0.
  - busy, done, timed_out and load_err = 0.
  - Applies immediately, including mid-load or mid-run.
- **States:** IDLE, LOAD, RST_HOLD, RUN, HALTED, TIMEOUT, ERROR.
- **core_rst:** 1 in every state except RUN.
- **IDLE/HALTED/TIMEOUT/ERROR + start:**
  - If skip_load=0: go to LOAD; clear words_loaded and the address counter.
  - If skip_load=1: go to RST_HOLD.
  - Counters clear on entry to RST_HOLD.
  - start is ignored in LOAD, RST_HOLD and RUN.
- **LOAD:**
  - ld_ready=1. On ld_valid&&ld_ready: registered imem_we=1, imem_addr=addr, imem_wdata=ld_data in the next cycle (1-cycle latency); addr++ and words_loaded++.
  - Transfer with ld_last=1: after the write, go to RST_HOLD.
  - Transfer at addr=2^ADDR_W-1 with ld_last=0: the word is written, then go to ERROR. No wrap-around.
  - ld_valid=0: stay in LOAD indefinitely.
- **RST_HOLD:** hold exactly RST_CYCLES cycles, then go to RUN. core_rst deasserts in the first RUN cycle.
- **RUN:**
  - cycle_count++ every cycle.
  - retire_count++ when core_retire=1 (halt cycle included).
  - Both counters saturate at all-ones.
  - core_halt=1: go to HALTED. Counters include that cycle.
  - cycle_count reaching TIMEOUT_CYCLES (when nonzero) with no halt: go to TIMEOUT.
  - Halt and timeout in the same cycle: HALTED wins.
- **HALTED/TIMEOUT/ERROR:** counters and words_loaded are frozen and readable. The core is held in reset.
- **Status outputs:** all registered and decoded from state.

Decomposition:
- Shared package proc_ctrl_pkg holds:
  - the state enum (3-bit encodings IDLE=0 … ERROR=6);
  - the default RST_CYCLES/TIMEOUT constants;
  - the lc-2k halt opcode constant, shared with the core and the bench.
- One sub-module: sat_counter (parameter W; inputs clr and inc; output value, saturating). Instantiated twice for the cycle and retire counters.

Test Plan:
- **Reset mid-RUN:** rst low at an arbitrary point -> core_rst=1, all counts 0, state IDLE in the same cycle (async).
- **Load and halt:** start, skip_load=0; load 2 words {lw 1 0 two, halt} with ld_last on word 2 -> imem writes at addr 0,1 and words_loaded=2. Then core_rst held RST_CYCLES=2 cycles. Core halts in its 2nd RUN cycle -> done=1, cycle_count=2, retire_count=2.
- **Watchdog:** TIMEOUT_CYCLES=16, core_halt never asserted -> timed_out=1 after exactly 16 RUN cycles. Then start with skip_load=1 -> RST_HOLD with counters cleared.
- **Halt vs. timeout:** core_halt asserted on cycle 16 with TIMEOUT_CYCLES=16 -> done=1, timed_out=0.
- **Load overflow:** ADDR_W=2, 4 words with no ld_last -> 4 writes, then load_err=1, core_rst stays 1.
- **Load back-pressure:** ld_valid toggled 1/0/1 -> only handshaken words are written, addresses contiguous. Core retire gaps (core_retire=0 on 3 cycles) -> retire_count = cycle_count-3.
